cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_FU, default 4, number of functional-unit completion ports.
REQ-002 Parameter CDB_WIDTH, default 3, broadcast lanes per cycle.
REQ-003 Parameter BUF_DEPTH, default 2, per-FU completion buffer entries (power of 2).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-low; state clears on a rising edge where reset==0.
REQ-006 flush  input  1  squash; discards all buffered and in-flight completions.
REQ-007 fu_valid  input  [N_FU]  FU presents a completion.
REQ-008 fu_tag  input  [N_FU] x $clog2(`ROB_SIZE)  ROB tag of the completing insn.
REQ-009 fu_value  input  [N_FU] x 32  result value.
REQ-010 fu_ready  output  [N_FU]  buffer can accept; transfer occurs when fu_valid & fu_ready.
REQ-011 complete_en  output  1  at least one lane valid this cycle.
REQ-012 CDB_tag_out  output  [CDB_WIDTH] x $clog2(`ROB_SIZE)  broadcast tags, feed Map_Table CDB_tag_in.
REQ-013 CDB_value_out  output  [CDB_WIDTH] x 32  broadcast values, to ROB/RS.
REQ-014 rob_complete_num  output  2  number of valid lanes, 0..3.

Function
REQ-015 Each FU port SHALL own a FIFO of BUF_DEPTH {tag,value} entries.
REQ-016 fu_ready[i] SHALL equal (count[i] < BUF_DEPTH) from registered state; a same-cycle pop SHALL NOT raise fu_ready.
REQ-017 Each cycle the arbiter SHALL grant up to CDB_WIDTH non-empty FIFO heads, scanning FUs round-robin from rr_ptr, one grant per FU per cycle.
REQ-018 Granted heads SHALL be packed into lanes 0..k-1 in scan order; lanes k..CDB_WIDTH-1 SHALL drive tag 0, value 0.
REQ-019 Outputs SHALL be registered: an entry accepted in cycle t is broadcast at the earliest in cycle t+1 (visible after edge t+1), never combinationally.
REQ-020 rob_complete_num SHALL equal k; complete_en SHALL equal (k != 0).
REQ-021 rr_ptr SHALL advance to (last granted FU + 1) mod N_FU when k>0, else hold; wrap-around at N_FU-1 -> 0.
REQ-022 Simultaneous push and pop on a full FIFO SHALL NOT occur (fu_ready low); on a non-full FIFO both SHALL take effect, count unchanged.
REQ-023 Per-FU ordering SHALL be preserved: entries from one FU broadcast in acceptance order.
REQ-024 flush SHALL empty all FIFOs and zero all outputs at the next edge, overriding same-cycle accepts and grants; rr_ptr resets to 0.
REQ-025 No entry SHALL be broadcast twice or dropped outside flush/reset.

Reset
REQ-026 On reset==0 at a clock edge: all FIFO counts/pointers 0, rr_ptr 0, complete_en 0, rob_complete_num 0, all CDB_tag_out/CDB_value_out 0; fu_ready all 1 from the following cycle.
REQ-027 Reset asserted mid-operation SHALL discard buffered entries exactly as flush.

Structure
REQ-028 `ROB_SIZE, CDB_WIDTH default and a CDB_PACKET struct {tag, value} SHALL live in the shared system-defines package.
REQ-029 One sub-module, cdb_fu_fifo (per-FU BUF_DEPTH FIFO), SHALL be instantiated N_FU times; arbitration stays in cdb_arbiter.

Verification
REQ-030 Reset, idle: fu_valid=0 for 5 cycles -> complete_en=0, rob_complete_num=0, fu_ready=4'b1111.
REQ-031 Single: FU0 tag 5 value 32'hA5 at cycle t -> cycle t+1 complete_en=1, num=1, CDB_tag_out[0]=5, value 32'hA5.
REQ-032 Oversubscribe: all 4 FUs valid once (tags 1,2,3,4), rr_ptr=0 -> first cycle num=3 tags {1,2,3}, next cycle num=1 tag 4, rr_ptr then 0.
REQ-033 Backpressure: FU2 valid every cycle with tags 6,7,8 while FU0,1,3 saturate -> fu_ready[2] drops at count 2; FU2 tags broadcast in order 6,7,8, none lost.
REQ-034 Wrap: rr_ptr=3, FUs 3 and 0 non-empty -> lanes {FU3, FU0}, rr_ptr becomes 1.
REQ-035 Flush: 5 entries buffered, flush=1 -> next cycle num=0, all fu_ready=1; no buffered tag ever appears on the CDB.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared system defines for the completion data bus: ROB sizing, lane defaults
// and the broadcast packet layout.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_SIZE          = 32;
  localparam int unsigned TAG_W             = $clog2(ROB_SIZE);
  localparam int unsigned VALUE_W           = 32;
  localparam int unsigned CDB_WIDTH_DEFAULT = 3;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [VALUE_W-1:0] value;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU completion buffer. When empty, the incoming completion is offered as the head
// so it can be broadcast on the next edge without first landing in storage.
module cdb_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  cdb_packet_t in_pkt_i,
  input  logic        grant_i,
  output logic        ready_o,
  output logic        head_valid_o,
  output cdb_packet_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  cdb_packet_t [Depth-1:0] mem_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]           count_q;
  logic                    empty, accept, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign empty        = (count_q == '0);
  assign ready_o      = (count_q < DepthCnt);
  assign accept       = in_valid_i & ready_o;
  assign head_valid_o = ~empty | accept;
  assign head_o       = empty ? in_pkt_i : mem_q[rd_ptr_q];
  // A granted bypass entry never enters storage.
  assign push         = accept & ~(grant_i & empty);
  assign pop          = grant_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_pkt_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion data bus arbiter: grants up to CDB_WIDTH FU buffer heads per cycle in
// round-robin order and broadcasts them from registered lanes.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_FU      = 4,
  parameter int unsigned CDB_WIDTH = CDB_WIDTH_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [N_FU-1:0]                     fu_valid,
  input  logic [N_FU-1:0][TAG_W-1:0]          fu_tag,
  input  logic [N_FU-1:0][VALUE_W-1:0]        fu_value,
  output logic [N_FU-1:0]                     fu_ready,
  output logic                                complete_en,
  output logic [CDB_WIDTH-1:0][TAG_W-1:0]     CDB_tag_out,
  output logic [CDB_WIDTH-1:0][VALUE_W-1:0]   CDB_value_out,
  output logic [1:0]                          rob_complete_num
);

  localparam int unsigned PtrW  = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int unsigned LaneW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

  cdb_packet_t [N_FU-1:0]      in_pkt, head;
  logic [N_FU-1:0]             head_valid, grant;
  cdb_packet_t [CDB_WIDTH-1:0] lane_q, lane_d;
  logic [PtrW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [1:0]                  num_q, num_d;
  logic                        en_q, en_d;

  for (genvar i = 0; i < N_FU; i++) begin : g_fifo
    assign in_pkt[i].tag   = fu_tag[i];
    assign in_pkt[i].value = fu_value[i];

    cdb_fu_fifo #(
      .Depth(BUF_DEPTH)
    ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .flush_i     (flush),
      .in_valid_i  (fu_valid[i]),
      .in_pkt_i    (in_pkt[i]),
      .grant_i     (grant[i]),
      .ready_o     (fu_ready[i]),
      .head_valid_o(head_valid[i]),
      .head_o      (head[i])
    );
  end

  always_comb begin
    int unsigned cnt;
    int unsigned idx;
    int unsigned last;
    grant  = '0;
    lane_d = '0;
    cnt    = 0;
    idx    = 0;
    last   = 0;
    for (int unsigned j = 0; j < N_FU; j++) begin
      idx = 32'(rr_ptr_q) + j;
      if (idx >= N_FU) idx = idx - N_FU;
      if (head_valid[PtrW'(idx)] && cnt < CDB_WIDTH) begin
        grant[PtrW'(idx)]   = 1'b1;
        lane_d[LaneW'(cnt)] = head[PtrW'(idx)];
        cnt  = cnt + 1;
        last = idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (cnt != 0) rr_ptr_d = (last == N_FU - 1) ? '0 : PtrW'(last + 1);
    num_d = 2'(cnt);
    en_d  = (cnt != 0);
  end

  // Flush wins over any same-cycle grant; the FIFOs drop their contents on the same edge.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rr_ptr_q <= '0;
      lane_q   <= '0;
      num_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
      num_q    <= num_d;
      en_q     <= en_d;
    end
  end

  for (genvar l = 0; l < CDB_WIDTH; l++) begin : g_lane
    assign CDB_tag_out[l]   = lane_q[l].tag;
    assign CDB_value_out[l] = lane_q[l].value;
  end

  assign complete_en      = en_q;
  assign rob_complete_num = num_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for packing/round-robin plus sequences for
// backpressure ordering, flush and mid-operation reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset, flush;
  logic [3:0]            fu_valid;
  logic [3:0][TAG_W-1:0] fu_tag;
  logic [3:0][31:0]      fu_value;
  logic [3:0]            fu_ready;
  logic                  complete_en;
  logic [2:0][TAG_W-1:0] cdb_tag;
  logic [2:0][31:0]      cdb_value;
  logic [1:0]            rob_complete_num;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] valid;
    int t0, t1, t2, t3;
    logic en;
    int num, l0, l1, l2;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .fu_valid        (fu_valid),
    .fu_tag          (fu_tag),
    .fu_value        (fu_value),
    .fu_ready        (fu_ready),
    .complete_en     (complete_en),
    .CDB_tag_out     (cdb_tag),
    .CDB_value_out   (cdb_value),
    .rob_complete_num(rob_complete_num)
  );

  function automatic logic [31:0] val_of(input int t);
    return 32'(t * 33);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input int t0, t1, t2, t3,
                              input logic en, input int num, l0, l1, l2);
    vec_t r;
    r.valid = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.t3 = t3;
    r.en = en; r.num = num; r.l0 = l0; r.l1 = l1; r.l2 = l2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int t0, t1, t2, t3);
    int t[4];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    fu_valid = v;
    for (int i = 0; i < 4; i++) begin
      fu_tag[i]   = TAG_W'(t[i]);
      fu_value[i] = val_of(t[i]);
    end
  endtask

  task automatic check_out(input string nm, input logic en, input int num,
                           input int l0, l1, l2, input logic [3:0] rdy);
    int l[3];
    l[0] = l0; l[1] = l1; l[2] = l2;
    chk({nm, " en"}, 32'(complete_en), 32'(en));
    chk({nm, " num"}, 32'(rob_complete_num), 32'(num));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s tag%0d", nm, k), 32'(cdb_tag[k]), 32'(l[k]));
      chk($sformatf("%s val%0d", nm, k), cdb_value[k], val_of(l[k]));
    end
    chk({nm, " ready"}, 32'(fu_ready), 32'(rdy));
  endtask

  function automatic int fu_of(input int t);
    if (t >= 12 && t <= 17) return 0;
    if (t >= 18 && t <= 23) return 1;
    if (t >= 6 && t <= 11) return 2;
    if (t >= 24 && t <= 29) return 3;
    return -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt[4];
    int bc[4];
    int base[4];
    logic [3:0] acc;
    bit seen_low;
    int n, t, f;

    reset = 1'b0;
    flush = 1'b0;
    drive(4'b0000, 0, 0, 0, 0);
    tick();
    tick();
    check_out("reset", 1'b0, 0, 0, 0, 0, 4'b1111);
    reset = 1'b1;

    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle en", 32'(complete_en), 32'd0);
      chk("idle num", 32'(rob_complete_num), 32'd0);
      chk("idle ready", 32'(fu_ready), 32'hf);
    end

    // rr_ptr trail: 0 ->1 ->1 ->0 ->3 ->0 ->3 ->1 ->1 ->1
    vecs[0] = mk(4'b0001, 5, 0, 0, 0, 1'b1, 1, 5, 0, 0);
    vecs[1] = mk(4'b0000, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    vecs[2] = mk(4'b1000, 0, 0, 0, 9, 1'b1, 1, 9, 0, 0);
    vecs[3] = mk(4'b1111, 1, 2, 3, 4, 1'b1, 3, 1, 2, 3);
    vecs[4] = mk(4'b0000, 0, 0, 0, 0, 1'b1, 1, 4, 0, 0);
    vecs[5] = mk(4'b1111, 10, 11, 12, 13, 1'b1, 3, 10, 11, 12);
    vecs[6] = mk(4'b0001, 14, 0, 0, 0, 1'b1, 2, 13, 14, 0);
    vecs[7] = mk(4'b0101, 16, 0, 15, 0, 1'b1, 2, 15, 16, 0);
    vecs[8] = mk(4'b0000, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].valid, vecs[k].t0, vecs[k].t1, vecs[k].t2, vecs[k].t3);
      tick();
      check_out($sformatf("vec%0d", k), vecs[k].en, vecs[k].num,
                vecs[k].l0, vecs[k].l1, vecs[k].l2, 4'b1111);
    end
    drive(4'b0000, 0, 0, 0, 0);

    // Backpressure: every FU offers six tags; FU2 starts at 6.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base[0] = 12; base[1] = 18; base[2] = 6; base[3] = 24;
    for (int i = 0; i < 4; i++) begin
      nxt[i] = 0;
      bc[i]  = 0;
    end
    seen_low = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bc[0] == 6 && bc[1] == 6 && bc[2] == 6 && bc[3] == 6) break;
      for (int i = 0; i < 4; i++) begin
        fu_valid[i] = (nxt[i] < 6);
        fu_tag[i]   = TAG_W'(base[i] + nxt[i]);
        fu_value[i] = val_of(base[i] + nxt[i]);
      end
      acc = fu_valid & fu_ready;
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) nxt[i]++;
      if (!fu_ready[2]) seen_low = 1'b1;
      n = int'(rob_complete_num);
      chk("bp en", 32'(complete_en), 32'(n != 0));
      for (int l = 0; l < 3; l++) begin
        if (l < n) begin
          t = int'(cdb_tag[l]);
          f = fu_of(t);
          if (f < 0) begin
            total++;
            bad++;
            $display("FAIL bp tag: got %0d want a tag from an FU range", t);
          end else begin
            chk("bp order", 32'(t), 32'(base[f] + bc[f]));
            chk("bp accepted", 32'(bc[f] < nxt[f]), 32'd1);
            chk("bp value", cdb_value[l], val_of(t));
            bc[f]++;
          end
        end else begin
          chk("bp pad tag", 32'(cdb_tag[l]), 32'd0);
          chk("bp pad val", cdb_value[l], 32'd0);
        end
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("bp count fu%0d", i), 32'(bc[i]), 32'd6);
    chk("bp ready2 dropped", 32'(seen_low), 32'd1);
    drive(4'b0000, 0, 0, 0, 0);

    // Flush with five entries buffered.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, c * 4 + 1, c * 4 + 2, c * 4 + 3, c * 4 + 4);
      tick();
      chk("fill num", 32'(rob_complete_num), 32'd3);
    end
    chk("fill ready", 32'(fu_ready), 32'h7);
    drive(4'b1111, 21, 22, 23, 24);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(4'b0000, 0, 0, 0, 0);
    check_out("flush", 1'b0, 0, 0, 0, 0, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("post flush", 1'b0, 0, 0, 0, 0, 4'b1111);
    end

    // Reset mid-operation discards buffered entries like flush.
    drive(4'b1111, 1, 2, 3, 4);
    tick();
    drive(4'b1111, 5, 6, 7, 8);
    tick();
    drive(4'b0000, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_out("mid reset", 1'b0, 0, 0, 0, 0, 4'b1111);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_out("post reset", 1'b0, 0, 0, 0, 0, 4'b1111);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
